row_sync_axi: RTL and testbench

- AXI4 master engine that moves one whole emulated DRAM row between the emulation memory cache and board memory.
- Sits downstream of the dimm cache controller, which issues a sync request (bank group, bank, cache slot, DRAM row, direction).
- Drives the dimm's m_axi_* port and the cache's sync-side memory port.
- Handles one request at a time as a single INCR burst per row.

---
 rtl/row_sync_axi.sv | 190 +++++++++++++++++++
 tb/tb_row_sync_axi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/row_sync_axi.sv
// row_sync_axi: moves one emulated DRAM row between the cache and board memory as a single AXI4 INCR burst
module row_sync_axi #(
    parameter int BGWIDTH        = 2,
    parameter int BAWIDTH        = 2,
    parameter int ADDRWIDTH      = 17,
    parameter int CHWIDTH        = 5,
    parameter int ROWBEATS       = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE = '0
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              req_valid,
    output logic                                              req_ready,
    input  logic                                              req_dir,
    input  logic [BGWIDTH-1:0]                                req_bg,
    input  logic [BAWIDTH-1:0]                                req_ba,
    input  logic [CHWIDTH-1:0]                                req_slot,
    input  logic [ADDRWIDTH-1:0]                              req_row,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              err,
    output logic [BGWIDTH+BAWIDTH+CHWIDTH+$clog2(ROWBEATS)-1:0] c_addr,
    output logic                                              c_we,
    output logic [AXI_DATA_WIDTH-1:0]                         c_wdata,
    input  logic [AXI_DATA_WIDTH-1:0]                         c_rdata,
    output logic [AXI_ID_WIDTH-1:0]                           m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]                         m_axi_awaddr,
    output logic [7:0]                                        m_axi_awlen,
    output logic [2:0]                                        m_axi_awsize,
    output logic [1:0]                                        m_axi_awburst,
    output logic                                              m_axi_awlock,
    output logic [3:0]                                        m_axi_awcache,
    output logic [2:0]                                        m_axi_awprot,
    output logic                                              m_axi_awvalid,
    input  logic                                              m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]                         m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]                       m_axi_wstrb,
    output logic                                              m_axi_wlast,
    output logic                                              m_axi_wvalid,
    input  logic                                              m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]                           m_axi_bid,
    input  logic [1:0]                                        m_axi_bresp,
    input  logic                                              m_axi_bvalid,
    output logic                                              m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]                           m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]                         m_axi_araddr,
    output logic [7:0]                                        m_axi_arlen,
    output logic [2:0]                                        m_axi_arsize,
    output logic [1:0]                                        m_axi_arburst,
    output logic                                              m_axi_arlock,
    output logic [3:0]                                        m_axi_arcache,
    output logic [2:0]                                        m_axi_arprot,
    output logic                                              m_axi_arvalid,
    input  logic                                              m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]                           m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]                         m_axi_rdata,
    input  logic [1:0]                                        m_axi_rresp,
    input  logic                                              m_axi_rlast,
    input  logic                                              m_axi_rvalid,
    output logic                                              m_axi_rready
);
    localparam int CW = $clog2(ROWBEATS);
    localparam int SB = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [CW-1:0] LAST = CW'(ROWBEATS - 1);

    typedef enum logic [3:0] {S_IDLE, S_AR, S_R, S_AW, S_WPRE, S_WLD, S_W, S_B, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BGWIDTH-1:0]        bg_q, bg_d;
    logic [BAWIDTH-1:0]        ba_q, ba_d;
    logic [CHWIDTH-1:0]        slot_q, slot_d;
    logic [ADDRWIDTH-1:0]      row_q, row_d;
    logic                      err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0] wd_q, wd_d;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic                      unused_ids;

    // each row occupies its own aligned block, so the shift keeps bursts inside one 4KB page
    assign addr = AXI_BASE + (AXI_ADDR_WIDTH'({bg_q, ba_q, row_q}) << (CW + SB));
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    assign req_ready = state_q == S_IDLE;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign err       = err_q;
    // in W the next word's address is presented early so it is ready during the one-cycle reload gap
    assign c_addr    = {bg_q, ba_q, slot_q, state_q == S_W ? cnt_q + CW'(1) : cnt_q};
    assign c_we      = state_q == S_R && m_axi_rvalid;
    assign c_wdata   = m_axi_rdata;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = 8'(ROWBEATS - 1);
    assign m_axi_awsize  = 3'(SB);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = state_q == S_AW;
    assign m_axi_wdata   = wd_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = state_q == S_W && cnt_q == LAST;
    assign m_axi_wvalid  = state_q == S_W;
    assign m_axi_bready  = state_q == S_B;
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = 8'(ROWBEATS - 1);
    assign m_axi_arsize  = 3'(SB);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = state_q == S_AR;
    assign m_axi_rready  = state_q == S_R;

    // state, beat counter, latched request and write data register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            slot_q  <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            slot_q  <= slot_d;
            row_q   <= row_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    // next-state: one request at a time, read or write burst, then a single done cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bg_d    = bg_q;
        ba_d    = ba_q;
        slot_d  = slot_q;
        row_d   = row_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                bg_d    = req_bg;
                ba_d    = req_ba;
                slot_d  = req_slot;
                row_d   = req_row;
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = req_dir ? S_AW : S_AR;
            end
            S_AR: state_d = m_axi_arready ? S_R : S_AR;
            S_R: if (m_axi_rvalid) begin
                cnt_d = cnt_q + CW'(1);
                if (m_axi_rresp != 2'b00 || m_axi_rlast != (cnt_q == LAST)) err_d = 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_AW:   state_d = m_axi_awready ? S_WPRE : S_AW;
            S_WPRE: state_d = S_WLD;
            S_WLD: begin
                wd_d    = c_rdata;
                state_d = S_W;
            end
            S_W: if (m_axi_wready) begin
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == LAST ? S_B : S_WLD;
            end
            S_B: if (m_axi_bvalid) begin
                if (m_axi_bresp != 2'b00) err_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_row_sync_axi.sv
// tb_row_sync_axi: directed bench for row_sync_axi with a cache model and a hand-driven AXI slave
module tb_row_sync_axi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req_valid, req_ready, req_dir;
    logic [1:0]  req_bg, req_ba;
    logic [4:0]  req_slot;
    logic [16:0] req_row;
    logic        busy, done, err;
    logic [12:0] c_addr;
    logic        c_we;
    logic [31:0] c_wdata, c_rdata;
    logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    row_sync_axi dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_bg(req_bg), .req_ba(req_ba), .req_slot(req_slot), .req_row(req_row),
        .busy(busy), .done(done), .err(err),
        .c_addr(c_addr), .c_we(c_we), .c_wdata(c_wdata), .c_rdata(c_rdata),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    logic [31:0] mem [0:8191];
    logic        pl_en;
    logic [12:0] pl_addr;
    logic [31:0] pl_data;

    // cache model: 1-cycle read latency, DUT writes plus bench preload port
    always @(posedge clk) begin
        if (c_we) mem[c_addr] <= c_wdata;
        if (pl_en) mem[pl_addr] <= pl_data;
        c_rdata <= mem[c_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [1:0] bg, input logic [1:0] ba, input logic [4:0] slot);
        for (int i = 0; i < 16; i++) begin
            pl_en = 1'b1;
            pl_addr = {bg, ba, slot, 4'(i)};
            pl_data = 32'(i * 3);
            @(negedge clk);
        end
        pl_en = 1'b0;
    endtask

    task automatic send_req(input logic dir, input logic [1:0] bg, input logic [1:0] ba,
                            input logic [4:0] slot, input logic [16:0] row);
        req_dir = dir; req_bg = bg; req_ba = ba; req_slot = slot; req_row = row;
        req_valid = 1'b1;
        #1 check("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_fetch(input logic [1:0] bg, input logic [1:0] ba, input logic [4:0] slot,
                             input logic [31:0] exp_addr, input int rlast_beat, input int err_beat,
                             input logic exp_err);
        for (int k = 0; k < 10 && !m_axi_arvalid; k++) @(negedge clk);
        check("arvalid", m_axi_arvalid, 1'b1);
        check("araddr", m_axi_araddr, exp_addr);
        check("arlen", m_axi_arlen, 8'd15);
        check("ar_consts", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot},
              {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        check("rready_before_ar", m_axi_rready, 1'b0);
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata = 32'hA0 + i;
            m_axi_rlast = (i == rlast_beat);
            m_axi_rresp = (i == err_beat) ? 2'b10 : 2'b00;
            #1;
            check("rready", m_axi_rready, 1'b1);
            check("c_we", c_we, 1'b1);
            check("c_addr", c_addr, {bg, ba, slot, 4'(i)});
            check("c_wdata", c_wdata, 32'hA0 + i);
            @(negedge clk);
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        #1;
        check("fetch_done", done, 1'b1);
        check("fetch_err", err, exp_err);
        check("c_we_after", c_we, 1'b0);
        check("req_ready_in_done", req_ready, 1'b0);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("req_ready_after_done", req_ready, 1'b1);
        check("busy_after_done", busy, 1'b0);
    endtask

    task automatic run_wb(input logic [31:0] exp_addr, input int aw_delay, input logic toggle,
                          input logic [1:0] bresp, input logic exp_err, input int abort_beat);
        int beat = 0;
        logic prev_hs = 1'b0, prev_gap = 1'b0, prev_v = 1'b0;
        for (int k = 0; k < 10 && !m_axi_awvalid; k++) @(negedge clk);
        check("awvalid", m_axi_awvalid, 1'b1);
        check("awaddr", m_axi_awaddr, exp_addr);
        check("awlen", m_axi_awlen, 8'd15);
        check("aw_consts", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_wstrb},
              {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF});
        check("w_before_aw", m_axi_wvalid, 1'b0);
        for (int k = 0; k < aw_delay; k++) begin
            @(negedge clk);
            check("aw_hold", m_axi_awvalid, 1'b1);
            check("w_before_aw", m_axi_wvalid, 1'b0);
        end
        m_axi_awready = 1'b1;
        @(negedge clk);
        m_axi_awready = 1'b0;
        for (int c = 0; c < 200 && beat < 16; c++) begin
            m_axi_wready = toggle ? c[0] : 1'b1;
            if (prev_hs) check("w_gap", m_axi_wvalid, 1'b0);
            else if (prev_gap || prev_v) check("w_valid_hold", m_axi_wvalid, 1'b1);
            if (beat == abort_beat && m_axi_wvalid) begin
                reset_n = 1'b0;
                m_axi_wready = 1'b0;
                #1;
                check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_req_ready", req_ready, 1'b1);
                check("rst_done_err", {done, err, c_we}, 3'b0);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("wdata", m_axi_wdata, 32'(beat * 3));
                check("wlast", m_axi_wlast, beat == 15);
                beat++;
            end
            prev_gap = prev_hs;
            prev_hs = m_axi_wvalid && m_axi_wready;
            prev_v = m_axi_wvalid;
            @(negedge clk);
        end
        m_axi_wready = 1'b0;
        check("w_beats", beat, 16);
        check("bready", m_axi_bready, 1'b1);
        check("wvalid_in_b", m_axi_wvalid, 1'b0);
        m_axi_bvalid = 1'b1;
        m_axi_bresp = bresp;
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00;
        #1;
        check("wb_done", done, 1'b1);
        check("wb_err", err, exp_err);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("req_ready_after_done", req_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_dir = 1'b0; req_bg = '0; req_ba = '0; req_slot = '0; req_row = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_bid = '0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0; m_axi_rid = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_busy_done_err", {busy, done, err, c_we}, 4'b0);
        check("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // clean fetch: {bg=1,ba=2,row=5} = 0xC0005, times 64 bytes per row
        send_req(1'b0, 2'd1, 2'd2, 5'd3, 17'd5);
        run_fetch(2'd1, 2'd2, 5'd3, 32'h0300_0140, 15, 99, 1'b0);

        // clean write back of the same slot after overwriting it with i*3
        preload(2'd1, 2'd2, 5'd3);
        send_req(1'b1, 2'd1, 2'd2, 5'd3, 17'd5);
        run_wb(32'h0300_0140, 0, 1'b0, 2'b00, 1'b0, 99);

        // write back under wready toggling and late awready, slave answers SLVERR
        preload(2'd3, 2'd0, 5'd17);
        send_req(1'b1, 2'd3, 2'd0, 5'd17, 17'h1ABCD);
        run_wb(32'h066A_F340, 5, 1'b1, 2'b10, 1'b1, 99);

        // request held while busy: fetch runs, held write back accepted only after done
        preload(2'd2, 2'd3, 5'd30);
        req_dir = 1'b0; req_bg = 2'd0; req_ba = 2'd1; req_slot = 5'd9; req_row = 17'h12345;
        req_valid = 1'b1;
        #1 check("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_dir = 1'b1; req_bg = 2'd2; req_ba = 2'd3; req_slot = 5'd30; req_row = 17'd7;
        #1 check("req_ready_busy", req_ready, 1'b0);
        run_fetch(2'd0, 2'd1, 5'd9, 32'h00C8_D140, 15, 99, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        check("held_req_accepted", busy, 1'b1);
        run_wb(32'h0580_01C0, 0, 1'b0, 2'b00, 1'b0, 99);

        // early rlast on beat 7 plus SLVERR on beat 3
        send_req(1'b0, 2'd1, 2'd2, 5'd3, 17'd5);
        run_fetch(2'd1, 2'd2, 5'd3, 32'h0300_0140, 7, 3, 1'b1);
        // rlast never asserted
        send_req(1'b0, 2'd1, 2'd2, 5'd3, 17'd5);
        run_fetch(2'd1, 2'd2, 5'd3, 32'h0300_0140, 99, 99, 1'b1);
        // clean request clears the sticky error
        send_req(1'b0, 2'd1, 2'd2, 5'd3, 17'd5);
        run_fetch(2'd1, 2'd2, 5'd3, 32'h0300_0140, 15, 99, 1'b0);

        // reset at W beat 6, then a full write back that must restart at beat 0
        send_req(1'b1, 2'd2, 2'd3, 5'd30, 17'd7);
        run_wb(32'h0580_01C0, 0, 1'b0, 2'b00, 1'b0, 6);
        send_req(1'b1, 2'd2, 2'd3, 5'd30, 17'd7);
        run_wb(32'h0580_01C0, 0, 1'b0, 2'b00, 1'b0, 99);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
